// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared types and node-record layout helpers for the Huffman codeword builder
package huff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } huff_state_t;

    // Node record layout, LSB first: id, parent, bit, level.
    function automatic int node_par_lsb(input int id_w);
        return id_w;
    endfunction

    function automatic int node_bit_pos(input int id_w);
        return 2 * id_w;
    endfunction

    function automatic int node_lvl_lsb(input int id_w);
        return 2 * id_w + 1;
    endfunction

    function automatic int node_width(input int id_w, input int lvl_w);
        return lvl_w + 1 + 2 * id_w;
    endfunction

    function automatic int huff_len(input int prefix_w, input int level);
        return prefix_w - level + 1;
    endfunction

endpackage

// File: rtl/huff_code_form.sv
// rtl/huff_code_form.sv - combinational codeword former: {prefix, level, bit} -> {word, len, level error}
module huff_code_form
    import huff_pkg::*;
#(
    parameter int PREFIX_W = 7,
    parameter int LVL_W    = 4,
    parameter int CODE_W   = PREFIX_W + 1,
    parameter int LEN_W    = $clog2(CODE_W + 1)
) (
    input  logic [PREFIX_W-1:0] i_prefix,
    input  logic [LVL_W-1:0]    i_level,
    input  logic                i_bit,
    output logic [CODE_W-1:0]   o_code_word,
    output logic [LEN_W-1:0]    o_code_len,
    output logic                o_lvl_err
);

    logic [PREFIX_W-1:0] w_upper;

    // Shifting right by the level leaves prefix[PREFIX_W-1:L] right-aligned with zeros above.
    always_comb begin
        w_upper     = i_prefix >> i_level;
        o_lvl_err   = (32'(i_level) > 32'(PREFIX_W));
        o_code_word = {w_upper, i_bit};
        o_code_len  = o_lvl_err ? '0 : LEN_W'(huff_len(PREFIX_W, 32'(i_level)));
    end

endmodule

// File: rtl/huff_code_assign.sv
// rtl/huff_code_assign.sv - Huffman codeword builder: node-record stream in, {id, word, len} stream out
module huff_code_assign
    import huff_pkg::*;
#(
    parameter int N_NODES  = 7,
    parameter int ID_W     = 4,
    parameter int LVL_W    = 4,
    parameter int PREFIX_W = 7,
    parameter int CODE_W   = PREFIX_W + 1,
    parameter int LEN_W    = $clog2(CODE_W + 1),
    parameter int CNT_W    = $clog2(N_NODES + 1),
    parameter int NODE_W   = LVL_W + 1 + 2 * ID_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [PREFIX_W-1:0] i_prefix,
    output logic                o_busy,
    output logic                o_done,
    input  logic                i_node_valid,
    output logic                o_node_ready,
    input  logic [NODE_W-1:0]   i_node_data,
    output logic                o_code_valid,
    input  logic                i_code_ready,
    output logic [ID_W-1:0]     o_code_id,
    output logic [CODE_W-1:0]   o_code_word,
    output logic [LEN_W-1:0]    o_code_len,
    output logic [CNT_W-1:0]    o_emit_cnt,
    output logic                o_err
);

    localparam int PAR_LSB = node_par_lsb(ID_W);
    localparam int BIT_POS = node_bit_pos(ID_W);
    localparam int LVL_LSB = node_lvl_lsb(ID_W);

    huff_state_t         r_state, w_state_nxt;
    logic [PREFIX_W-1:0] r_prefix;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [CNT_W-1:0]    r_emit_cnt;
    logic                r_err;
    logic                r_s1_valid;
    logic [NODE_W-1:0]   r_s1_data;
    logic                r_code_valid;
    logic [ID_W-1:0]     r_code_id;
    logic [CODE_W-1:0]   r_code_word;
    logic [LEN_W-1:0]    r_code_len;

    logic                w_s1_adv;
    logic                w_node_ready;
    logic                w_node_acc;
    logic                w_emit;
    logic                w_lvl_err;
    logic [CODE_W-1:0]   w_word;
    logic [LEN_W-1:0]    w_len;
    logic [ID_W-1:0]     w_id;
    logic [ID_W-1:0]     w_par;

    assign w_id  = r_s1_data[ID_W-1:0];
    assign w_par = r_s1_data[PAR_LSB +: ID_W];

    huff_code_form #(
        .PREFIX_W (PREFIX_W),
        .LVL_W    (LVL_W),
        .CODE_W   (CODE_W),
        .LEN_W    (LEN_W)
    ) u_form (
        .i_prefix    (r_prefix),
        .i_level     (r_s1_data[LVL_LSB +: LVL_W]),
        .i_bit       (r_s1_data[BIT_POS]),
        .o_code_word (w_word),
        .o_code_len  (w_len),
        .o_lvl_err   (w_lvl_err)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_s1_adv     = r_s1_valid && (!r_code_valid || i_code_ready);
        w_node_ready = (r_state == ST_RUN) && (!r_s1_valid || w_s1_adv);
        w_node_acc   = w_node_ready && i_node_valid;
        w_emit       = (w_id != w_par) && !w_lvl_err;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_node_acc && (r_acc_cnt == CNT_W'(N_NODES - 1))) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (!r_s1_valid && !r_code_valid) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_prefix     <= '0;
            r_acc_cnt    <= '0;
            r_emit_cnt   <= '0;
            r_err        <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_code_valid <= 1'b0;
            r_code_id    <= '0;
            r_code_word  <= '0;
            r_code_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && i_start) begin
                r_prefix   <= i_prefix;
                r_err      <= 1'b0;
                r_emit_cnt <= '0;
                r_acc_cnt  <= '0;
            end else begin
                if (w_node_acc) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                if (w_s1_adv && w_lvl_err) r_err <= 1'b1;
                if (r_code_valid && i_code_ready) r_emit_cnt <= r_emit_cnt + CNT_W'(1);
            end
            // Stage 1 refills on the same edge it drains, keeping one record per cycle.
            if (w_node_acc) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= i_node_data;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_adv && w_emit) begin
                r_code_valid <= 1'b1;
                r_code_id    <= w_id;
                r_code_word  <= w_word;
                r_code_len   <= w_len;
            end else if (i_code_ready) begin
                r_code_valid <= 1'b0;
            end
        end
    end

    assign o_busy       = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign o_done       = (r_state == ST_DONE);
    assign o_node_ready = w_node_ready;
    assign o_code_valid = r_code_valid;
    assign o_code_id    = r_code_id;
    assign o_code_word  = r_code_word;
    assign o_code_len   = r_code_len;
    assign o_emit_cnt   = r_emit_cnt;
    assign o_err        = r_err;

endmodule
